// File: rtl/rep_add_mul_pkg.sv
// Shared definitions for the repeated-addition multiplier controller:
// state encoding, default counter width and a small busy-decode helper.
package rep_add_mul_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_ADD    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_A = ST_LOAD_A,
    LOAD_B = ST_LOAD_B,
    ADD    = ST_ADD,
    DONE   = ST_DONE
  } state_t;

  // An operation is in flight from the first operand load until the last add.
  function automatic logic state_is_busy(input state_t s);
    return (s == LOAD_A) || (s == LOAD_B) || (s == ADD);
  endfunction

endpackage

// File: rtl/rep_add_iter_cnt.sv
// Iteration counter: synchronous clear, increment, saturation at MAX and a
// terminal flag that the controller uses as its timeout condition.
module rep_add_iter_cnt #(
  parameter int          W   = 16,
  parameter int unsigned MAX = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_reg;

  assign at_max = (cnt_reg == MAX_V);
  assign cnt    = cnt_reg;

  // Increment is suppressed at the limit so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc && !at_max) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/rep_add_mul_ctrl.sv
// Controller for a repeated-addition multiplier: loads A then B from a shared
// bus, issues add/decrement pairs until B reaches zero or the iteration limit.
module rep_add_mul_ctrl
  import rep_add_mul_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_DEF,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             eqz,
  output logic             sel_b,
  output logic             lda,
  output logic             ldb,
  output logic             clrp,
  output logic             ldp,
  output logic             decb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  state_t state_reg, state_next;
  logic   err_reg, err_next;
  logic   cnt_clr, cnt_inc, cnt_at_max;

  rep_add_iter_cnt #(
    .W   (CNT_W),
    .MAX (MAX_ITER)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (iter_cnt),
    .at_max (cnt_at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    lda        = 1'b0;
    ldb        = 1'b0;
    clrp       = 1'b0;
    ldp        = 1'b0;
    decb       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD_A;
      end
      LOAD_A: begin
        lda        = 1'b1;
        state_next = LOAD_B;
      end
      LOAD_B: begin
        ldb        = 1'b1;
        clrp       = 1'b1;
        cnt_clr    = 1'b1;
        err_next   = 1'b0;
        state_next = ADD;
      end
      ADD: begin
        // B==0 wins over the timeout so an exact-limit multiply is not a fault.
        if (eqz) begin
          err_next   = 1'b0;
          state_next = DONE;
        end else if (cnt_at_max) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          ldp     = 1'b1;
          decb    = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides everything, including a start seen in IDLE.
    if (abort) begin
      state_next = IDLE;
      err_next   = 1'b0;
      lda        = 1'b0;
      ldb        = 1'b0;
      clrp       = 1'b0;
      ldp        = 1'b0;
      decb       = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
    end
  end

  assign sel_b = (state_reg == LOAD_B);
  assign busy  = state_is_busy(state_reg);
  assign done  = (state_reg == DONE);
  assign err   = err_reg;

endmodule

// File: tb/tb_rep_add_mul_ctrl.sv
// Directed bench for rep_add_mul_ctrl with a behavioural A/B/P datapath;
// a second instance with a small iteration limit exercises the timeout.
module tb_rep_add_mul_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic eqz;
  logic sel_b, lda, ldb, clrp, ldp, decb, busy, done, err;
  logic [15:0] iter_cnt;

  logic start2 = 1'b0;
  logic sel_b2, lda2, ldb2, clrp2, ldp2, decb2, busy2, done2, err2;
  logic [15:0] iter_cnt2;

  logic [15:0] op_a = '0, op_b = '0;
  logic [15:0] a_r = '0, b_r = '0;
  logic [31:0] p_r = '0;
  logic [15:0] bus;

  always #5 clk = ~clk;

  rep_add_mul_ctrl #(.CNT_W(16), .MAX_ITER(65535)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .eqz(eqz),
    .sel_b(sel_b), .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
    .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
  );

  rep_add_mul_ctrl #(.CNT_W(16), .MAX_ITER(3)) dut_lim (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .eqz(1'b0),
    .sel_b(sel_b2), .lda(lda2), .ldb(ldb2), .clrp(clrp2), .ldp(ldp2), .decb(decb2),
    .busy(busy2), .done(done2), .err(err2), .iter_cnt(iter_cnt2)
  );

  // Datapath model driven by the controller's strobes.
  assign bus = sel_b ? op_b : op_a;
  assign eqz = (b_r == 16'd0);
  always @(posedge clk) begin
    if (lda) a_r <= bus;
    if (ldb) b_r <= bus;
    else if (decb) b_r <= b_r - 16'd1;
    if (clrp) p_r <= '0;
    else if (ldp) p_r <= p_r + {16'd0, a_r};
  end

  int chk_cnt = 0, pass_cnt = 0;
  int cyc, n_ldp, n_decb, n_lda, n_done, first_ldp, last_ldp, done_cyc;
  int n_ldp2, n_done2, done_cyc2;
  logic err_at_done, busy_at_done, err2_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr_stats();
    cyc = -1; n_ldp = 0; n_decb = 0; n_lda = 0; n_done = 0;
    first_ldp = -1; last_ldp = -1; done_cyc = -1;
    n_ldp2 = 0; n_done2 = 0; done_cyc2 = -1;
    err_at_done = 1'bx; busy_at_done = 1'bx; err2_at_done = 1'bx;
  endtask

  // One clock cycle: drive this cycle's inputs, then sample the outputs.
  task automatic tick(input logic s, input logic ab, input logic r, input logic s2);
    @(posedge clk); #1;
    cyc++;
    start = s; abort = ab; rst = r; start2 = s2;
    #1;
    if (ldp) begin
      n_ldp++;
      if (first_ldp < 0) first_ldp = cyc;
      last_ldp = cyc;
    end
    if (decb) n_decb++;
    if (lda) n_lda++;
    if (done) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc;
      err_at_done = err;
      busy_at_done = busy;
    end
    if (ldp2) n_ldp2++;
    if (done2) begin
      n_done2++;
      if (done_cyc2 < 0) done_cyc2 = cyc;
      err2_at_done = err2;
    end
  endtask

  initial begin
    clr_stats();
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    check("rst_strobes", {23'd0, sel_b, lda, ldb, clrp, ldp, decb, busy, done, err}, 32'd0);
    check("rst_iter_cnt", {16'd0, iter_cnt}, 32'd0);
    check("rst_lim_outputs", {7'd0, iter_cnt2, sel_b2, lda2, ldb2, clrp2, ldp2, decb2, busy2, done2, err2}, 32'd0);

    // 17 x 5
    op_a = 16'd17; op_b = 16'd5;
    clr_stats();
    tick(1, 0, 0, 0);
    repeat (12) tick(0, 0, 0, 0);
    check("mul5_ldp_count", n_ldp, 5);
    check("mul5_decb_count", n_decb, 5);
    check("mul5_first_ldp", first_ldp, 3);
    check("mul5_last_ldp", last_ldp, 7);
    check("mul5_done_cycle", done_cyc, 9);
    check("mul5_done_count", n_done, 1);
    check("mul5_err", {31'd0, err_at_done}, 0);
    check("mul5_busy_at_done", {31'd0, busy_at_done}, 0);
    check("mul5_product", p_r, 85);
    check("mul5_iter_cnt", {16'd0, iter_cnt}, 5);

    // 123 x 0
    op_a = 16'd123; op_b = 16'd0;
    clr_stats();
    tick(1, 0, 0, 0);
    repeat (7) tick(0, 0, 0, 0);
    check("mul0_ldp_count", n_ldp, 0);
    check("mul0_done_cycle", done_cyc, 4);
    check("mul0_product", p_r, 0);
    check("mul0_iter_cnt", {16'd0, iter_cnt}, 0);

    // 4 x 10 aborted in cycle 6
    op_a = 16'd4; op_b = 16'd10;
    clr_stats();
    tick(1, 0, 0, 0);
    repeat (5) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    check("abort_cycle_strobes", {30'd0, ldp, decb}, 0);
    tick(0, 0, 0, 0);
    check("abort_next_idle", {30'd0, busy, done}, 0);
    repeat (6) tick(0, 0, 0, 0);
    check("abort_ldp_count", n_ldp, 3);
    check("abort_no_done", n_done, 0);
    check("abort_partial_p", p_r, 12);
    op_b = 16'd2;
    clr_stats();
    tick(1, 0, 0, 0);
    repeat (8) tick(0, 0, 0, 0);
    check("after_abort_done_cycle", done_cyc, 6);
    check("after_abort_product", p_r, 8);
    check("after_abort_err", {31'd0, err_at_done}, 0);

    // Timeout with limit 3 and eqz stuck low
    clr_stats();
    tick(0, 0, 0, 1);
    repeat (10) tick(0, 0, 0, 0);
    check("timeout_ldp_count", n_ldp2, 3);
    check("timeout_done_cycle", done_cyc2, 7);
    check("timeout_done_count", n_done2, 1);
    check("timeout_err", {31'd0, err2_at_done}, 1);
    check("timeout_iter_cnt", {16'd0, iter_cnt2}, 3);

    // Reset in the middle of ADD, then a run with stray start pulses
    op_a = 16'd9; op_b = 16'd7;
    clr_stats();
    tick(1, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    check("pre_rst_iter_cnt", {16'd0, iter_cnt}, 1);
    tick(0, 0, 0, 0);
    check("mid_rst_strobes", {23'd0, sel_b, lda, ldb, clrp, ldp, decb, busy, done, err}, 0);
    check("mid_rst_iter_cnt", {16'd0, iter_cnt}, 0);
    repeat (4) tick(0, 0, 0, 0);
    check("mid_rst_no_done", n_done, 0);
    clr_stats();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    repeat (8) tick(0, 0, 0, 0);
    check("stray_start_done_count", n_done, 1);
    check("stray_start_done_cycle", done_cyc, 11);
    check("stray_start_product", p_r, 63);
    check("stray_start_lda_count", n_lda, 1);

    // start and abort together in IDLE
    clr_stats();
    tick(1, 1, 0, 0);
    repeat (5) tick(0, 0, 0, 0);
    check("start_abort_lda", n_lda, 0);
    check("start_abort_busy", {31'd0, busy}, 0);
    check("start_abort_done", n_done, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
